// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module mdu_iter #(
  parameter int XLEN      = 64,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [2:0] op_q;
  logic w_q, neg_q, div0_q, ovf_q, ill_q;
  logic accept, sg1, sg2, n1, n2, is_div, ill, div0, ovf, fast, early, neg;
  logic [XLEN-1:0] x1, x2, m1, m2, min_in;
  logic [XLEN:0] sh, diff, sum;
  logic [XLEN-1:0] dhi, dlo, mhi, mlo, q, r, mres, dres, res, fin;
  logic [2*XLEN-1:0] prod, pres;
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready & in_valid & ~flush;
  always_comb begin
    is_div = op[2];
    sg1    = ~op[0] | (op == 3'b001);
    sg2    = sg1 & (op != 3'b010);
    x1     = op_w ? {{(XLEN-32){sg1 & src1[31]}}, src1[31:0]} : src1;
    x2     = op_w ? {{(XLEN-32){sg2 & src2[31]}}, src2[31:0]} : src2;
    n1     = sg1 & x1[XLEN-1];
    n2     = sg2 & x2[XLEN-1];
    m1     = n1 ? -x1 : x1;
    m2     = n2 ? -x2 : x2;
    min_in = op_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    ill    = op_w & ~op[2] & (op[1:0] != 2'b00);
    div0   = is_div & (x2 == '0);
    ovf    = is_div & sg1 & (x1 == min_in) & (&x2);
`ifdef MDU_FAST_MUL_EN
    fast   = ~is_div;
`else
    fast   = 1'b0;
`endif
    early  = ill | fast | (EARLY_OUT & (div0 | ovf));
    neg    = n1 ^ (n2 & ~(is_div & op[1]));
  end
  // One restoring-divide step and one shift-add step share the hi/lo/opnd registers.
  always_comb begin
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, opnd};
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    dhi  = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    dlo  = {lo[XLEN-2:0], ~diff[XLEN]};
    mhi  = sum[XLEN:1];
    mlo  = {sum[0], lo[XLEN-1:1]};
  end
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod = {{XLEN{1'b0}}, opnd} * {{XLEN{1'b0}}, lo};
`else
    prod = w_q ? {32'b0, hi, lo[XLEN-1:32]} : {hi, lo};
`endif
    pres = neg_q ? -prod : prod;
    mres = op_q[1:0] == 2'b00 ? pres[XLEN-1:0] : pres[2*XLEN-1:XLEN];
    q    = neg_q ? -lo : lo;
    r    = neg_q ? -hi : hi;
    dres = op_q[1] ? (div0_q ? opnd : ovf_q ? '0 : r)
                   : (div0_q ? '1 : ovf_q ? (w_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}) : q);
    res  = ill_q ? '0 : op_q[2] ? dres : mres;
    fin  = w_q ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  end
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (in_valid ? CALC : IDLE) :
               state == CALC ? (cnt == '0 ? DONE : CALC) :
               out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      cnt    <= early ? '0 : op_w ? CW'(32) : CW'(XLEN);
      hi     <= '0;
      lo     <= is_div ? (op_w ? {m1[31:0], {(XLEN-32){1'b0}}} : m1) : m2;
      opnd   <= is_div ? (div0 ? src1 : m2) : m1;
      op_q   <= op;
      w_q    <= op_w;
      neg_q  <= neg;
      div0_q <= div0;
      ovf_q  <= ovf;
      ill_q  <= ill;
    end else if (state == CALC) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        hi  <= op_q[2] ? dhi : mhi;
        lo  <= op_q[2] ? dlo : mlo;
      end else out_data <= fin;
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter against a behavioural RV64M model.
module tb_mdu_iter;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0, op_w = 0;
  logic in_ready, out_valid, busy;
  logic [2:0] op = 0;
  logic [63:0] src1 = 0, src2 = 0, out_data;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [63:0] d; int lat;} exp_t;
  exp_t sb[$];
  mdu_iter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_w(op_w), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] x, y;
    logic [31:0] r;
    logic signed [127:0] sa, sb2, ub_s;
    logic [127:0] ua, ub, p;
    logic signed [63:0] sx, sy;
    logic ov32, ov64;
    x = a[31:0]; y = b[31:0];
    sx = a; sy = b;
    ov32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ov64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    if (w) begin
      case (o)
        3'd0: r = 32'(x * y);
        3'd4: r = (y == 0) ? '1 : ov32 ? x : 32'(x / y);
        3'd5: r = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
        3'd6: r = (y == 0) ? x : ov32 ? '0 : 32'(x % y);
        3'd7: r = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: r = '0;
      endcase
      return {{32{r[31]}}, r};
    end
    sa = sx; sb2 = sy; ua = a; ub = b; ub_s = $signed(ub);
    case (o)
      3'd0, 3'd1: p = sa * sb2;
      3'd2: p = sa * ub_s;
      3'd3: p = ua * ub;
      default: p = '0;
    endcase
    case (o)
      3'd0: return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4: return (b == 0) ? '1 : ov64 ? a : 64'(sx / sy);
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: return (b == 0) ? a : ov64 ? '0 : 64'(sx % sy);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic zero, ov;
    if (w && !o[2] && o[1:0] != 0) return 1;
    if (!o[2]) return FAST ? 1 : (w ? 33 : 65);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ov = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ov) ? 1 : (w ? 33 : 65);
  endfunction
  task automatic run(input string tag, input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b, input int hold);
    int lat = 0, t = 0;
    exp_t e;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    check({tag, "_idle"}, in_ready, 1);
    op = o; op_w = w; src1 = a; src2 = b; in_valid = 1;
    sb.push_back(exp_t'{d: model(o, w, a, b), lat: exp_lat(o, w, a, b)});
    @(posedge clk); #1 in_valid = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check(tag, out_data, e.d);
    check({tag, "_busy_rdy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_data"}, out_data, e.d);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    check({tag, "_drop"}, out_valid, 0);
  endtask
  initial begin
    logic [63:0] a, b;
    logic [2:0] o;
    logic w;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    run("mul", 3'd0, 0, 64'd3, -64'sd5, 0);
    run("mulhu", 3'd3, 0, '1, '1, 0);
    run("mulhsu", 3'd2, 0, '1, 64'd2, 0);
    run("mulh", 3'd1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run("div0", 3'd4, 0, 64'd7, 64'd0, 0);
    run("rem0", 3'd6, 0, 64'd7, 64'd0, 0);
    run("divovf", 3'd4, 0, 64'h8000_0000_0000_0000, '1, 0);
    run("removf", 3'd6, 0, 64'h8000_0000_0000_0000, '1, 0);
    run("rem_neg", 3'd6, 0, -64'sd7, 64'd2, 0);
    run("div_neg", 3'd4, 0, -64'sd7, 64'd2, 0);
    run("divuw", 3'd5, 1, 64'hFFFF_FFFF, 64'd1, 0);
    run("remw_ovf", 3'd6, 1, 64'h8000_0000, '1, 0);
    run("mulw", 3'd0, 1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0003, 0);
    run("mulhw_ill", 3'd1, 1, 64'd5, 64'd6, 0);
    run("divu", 3'd5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 5);
    // Flush mid-CALC: the killed divide must never present a result.
    op = 3'd4; op_w = 0; src1 = 64'd100; src2 = 64'd7; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("flush_novalid", out_valid, 0);
    end
    flush = 1;
    @(posedge clk); #1 flush = 0;
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    run("after_flush", 3'd7, 0, 64'd100, 64'd7, 0);
    in_valid = 1; flush = 1;
    @(posedge clk); #1 in_valid = 0; flush = 0;
    check("flush_beats_accept", busy, 0);
    op = 3'd4; src1 = 64'd1000; src2 = 64'd3; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_data", out_data, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    run("after_rst", 3'd4, 0, 64'd1000, 64'd3, 0);
    for (int k = 0; k < 16; k++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        default: ;
      endcase
      run("rand", o, w, a, b, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
